// File: rtl/oisc_loader_if.sv
// Byte-stream input and memory-write/core-control outputs of the OISC image loader.
interface oisc_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_d_out;
    logic        mem_w_en;
    logic        core_rst;
    logic        done;
    logic        err;

    // loader side
    modport slave (
        input  rx_valid, rx_byte,
        output rx_ready, mem_addr, mem_d_out, mem_w_en, core_rst, done, err
    );

    // host / byte source side
    modport master (
        output rx_valid, rx_byte,
        input  rx_ready, mem_addr, mem_d_out, mem_w_en, core_rst, done, err
    );
endinterface

// File: rtl/oisc_loader.sv
// OISC image loader: parses a framed byte stream (sync, length, base, words,
// checksum), writes each 16-bit word to memory, and releases the core only
// when the whole image arrived with a good checksum.
module oisc_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_WORDS = 1024
) (
    input logic        clk,
    input logic        rst,
    oisc_loader_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, LEN_LO, LEN_HI, ADDR_LO, ADDR_HI,
        DATA_LO, DATA_HI, WRITE, CSUM, RUN, ERROR
    } state_t;

    state_t      state, state_n;
    logic [15:0] count, count_n;     // words still to write
    logic [15:0] ptr, ptr_n;         // next write address
    logic [7:0]  sum, sum_n;         // running checksum
    logic [7:0]  lo, lo_n;           // latched low data byte
    logic [15:0] addr_q, addr_n;     // write port address, held between writes
    logic [15:0] data_q, data_n;     // write port data, held between writes
    logic        xfer;
    logic [15:0] len_full;

    assign xfer     = bus.rx_valid && bus.rx_ready;
    assign len_full = {bus.rx_byte, count[7:0]};

    // Port outputs are pure decodes of state plus the held address/data.
    // The write strobe is masked by rst so a reset landing on WRITE never writes.
    assign bus.rx_ready  = (state != WRITE) && (state != RUN) && (state != ERROR);
    assign bus.mem_w_en  = (state == WRITE) && !rst;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_d_out = data_q;
    assign bus.core_rst  = (state != RUN);
    assign bus.done      = (state == RUN);
    assign bus.err       = (state == ERROR);

    // State and datapath registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            ptr    <= '0;
            sum    <= '0;
            lo     <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            ptr    <= ptr_n;
            sum    <= sum_n;
            lo     <= lo_n;
            addr_q <= addr_n;
            data_q <= data_n;
        end
    end

    // Next-state and datapath updates; byte states only move on a transfer.
    always_comb begin
        state_n = state;
        count_n = count;
        ptr_n   = ptr;
        sum_n   = sum;
        lo_n    = lo;
        addr_n  = addr_q;
        data_n  = data_q;
        unique case (state)
            IDLE: if (xfer && bus.rx_byte == SYNC_BYTE) begin
                sum_n   = '0;
                state_n = LEN_LO;
            end
            LEN_LO: if (xfer) begin
                count_n[7:0] = bus.rx_byte;
                sum_n        = sum + bus.rx_byte;
                state_n      = LEN_HI;
            end
            LEN_HI: if (xfer) begin
                count_n[15:8] = bus.rx_byte;
                sum_n         = sum + bus.rx_byte;
                state_n       = (32'(len_full) > MAX_WORDS) ? ERROR : ADDR_LO;
            end
            ADDR_LO: if (xfer) begin
                ptr_n[7:0] = bus.rx_byte;
                sum_n      = sum + bus.rx_byte;
                state_n    = ADDR_HI;
            end
            ADDR_HI: if (xfer) begin
                ptr_n[15:8] = bus.rx_byte;
                sum_n       = sum + bus.rx_byte;
                state_n     = (count == 16'd0) ? CSUM : DATA_LO;
            end
            DATA_LO: if (xfer) begin
                lo_n    = bus.rx_byte;
                sum_n   = sum + bus.rx_byte;
                state_n = DATA_HI;
            end
            DATA_HI: if (xfer) begin
                // capture the whole word now so WRITE only has to strobe
                addr_n  = ptr;
                data_n  = {bus.rx_byte, lo};
                sum_n   = sum + bus.rx_byte;
                state_n = WRITE;
            end
            WRITE: begin
                ptr_n   = ptr + 16'd1;
                count_n = count - 16'd1;
                state_n = (count == 16'd1) ? CSUM : DATA_LO;
            end
            CSUM: if (xfer) begin
                state_n = (bus.rx_byte == sum) ? RUN : ERROR;
            end
            RUN:     state_n = RUN;
            ERROR:   state_n = ERROR;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_oisc_loader.sv
// Bench for oisc_loader: fixed frame table, hand-written reset/boundary
// sequences, then random frames checked against a frame-level parser model.
module tb_oisc_loader;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         MAXW = 1024;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        string       name;
        int          n;
        logic [7:0]  b[16];
        int          gap;
        bit          done;
        bit          err;
        int          nw;
        logic [15:0] a[2];
        logic [15:0] d[2];
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    oisc_loader_if bus();

    oisc_loader #(.SYNC_BYTE(SYNC), .MAX_WORDS(MAXW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] cap_a[$];
    logic [15:0] cap_d[$];
    logic        cap_r[$];
    logic [15:0] exp_a[$];
    logic [15:0] exp_d[$];

    vec_t tbl[6];

    // capture every write strobe, sampled just after the falling edge
    always begin
        @(negedge clk);
        #1;
        if (bus.mem_w_en === 1'b1) begin
            cap_a.push_back(bus.mem_addr);
            cap_d.push_back(bus.mem_d_out);
            cap_r.push_back(bus.rx_ready);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t = 0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        while (bus.rx_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            n_chk++;
            $display("FAIL send_timeout: byte %0h not accepted within 40 cycles", b);
        end
        @(posedge clk);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic send_all(input bq_t q, input int gap);
        foreach (q[k]) send(q[k], gap);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic do_reset(input logic offer_valid, input logic [7:0] offer);
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_valid = offer_valid;
        bus.rx_byte  = offer;
        @(negedge clk);
        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        #2;
        cap_a.delete();
        cap_d.delete();
        cap_r.delete();
    endtask

    task automatic cmp_writes(input string nm);
        chk({nm, ".nwrites"}, cap_a.size(), exp_a.size());
        for (int k = 0; k < exp_a.size() && k < cap_a.size(); k++) begin
            chk($sformatf("%s.addr%0d", nm, k), cap_a[k], exp_a[k]);
            chk($sformatf("%s.data%0d", nm, k), cap_d[k], exp_d[k]);
        end
    endtask

    task automatic cmp_end(input string nm, input bit dn, input bit er);
        chk({nm, ".done"}, bus.done, dn);
        chk({nm, ".err"}, bus.err, er);
        chk({nm, ".core_rst"}, bus.core_rst, !dn);
    endtask

    // Frame-level reference: scan for sync, parse the header, lay words out
    // from base upward (16-bit wrap), and judge the trailing byte against the
    // mod-256 sum of everything between sync and checksum.
    function automatic void model(input bq_t b, output bit m_done, output bit m_err);
        int          i = 0;
        int          len;
        logic [15:0] base;
        logic [7:0]  s;
        exp_a.delete();
        exp_d.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        while (i < b.size() && b[i] != SYNC) i++;
        i++;
        len = int'(b[i]) + 256 * int'(b[i+1]);
        s   = b[i] + b[i+1];
        i  += 2;
        if (len > MAXW) begin
            m_err = 1'b1;
            return;
        end
        base = {b[i+1], b[i]};
        s    = s + b[i] + b[i+1];
        i   += 2;
        for (int k = 0; k < len; k++) begin
            exp_a.push_back(base + 16'(k));
            exp_d.push_back({b[i+1], b[i]});
            s  = s + b[i] + b[i+1];
            i += 2;
        end
        if (b[i] == s) m_done = 1'b1;
        else           m_err  = 1'b1;
    endfunction

    task automatic setv(input int idx, input string nm, input bq_t q, input int gap,
                        input bit dn, input bit er, input int nw,
                        input logic [15:0] a0, input logic [15:0] d0,
                        input logic [15:0] a1, input logic [15:0] d1);
        tbl[idx].name = nm;
        tbl[idx].n    = q.size();
        foreach (q[k]) tbl[idx].b[k] = q[k];
        tbl[idx].gap  = gap;
        tbl[idx].done = dn;
        tbl[idx].err  = er;
        tbl[idx].nw   = nw;
        tbl[idx].a[0] = a0; tbl[idx].d[0] = d0;
        tbl[idx].a[1] = a1; tbl[idx].d[1] = d1;
    endtask

    initial begin
        bq_t q;
        bit  m_done, m_err;

        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;

        // checksums are the mod-256 sum of the bytes between sync and checksum
        setv(0, "nominal",   '{8'hA5,8'h02,8'h00,8'h10,8'h00,8'h34,8'h12,8'h78,8'h56,8'h26}, 0, 1, 0, 2, 16'h0010, 16'h1234, 16'h0011, 16'h5678);
        setv(1, "bad_csum",  '{8'hA5,8'h02,8'h00,8'h10,8'h00,8'h34,8'h12,8'h78,8'h56,8'h27}, 0, 0, 1, 2, 16'h0010, 16'h1234, 16'h0011, 16'h5678);
        setv(2, "csum_dc",   '{8'hA5,8'h02,8'h00,8'h10,8'h00,8'h34,8'h12,8'h78,8'h56,8'hDC}, 1, 0, 1, 2, 16'h0010, 16'h1234, 16'h0011, 16'h5678);
        setv(3, "zero_noise",'{8'h00,8'hFF,8'hA5,8'h00,8'h00,8'h00,8'h80,8'h80}, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
        setv(4, "oversize",  '{8'hA5,8'h01,8'h04}, 0, 0, 1, 0, 16'h0, 16'h0, 16'h0, 16'h0);
        setv(5, "wrap_bp",   '{8'hA5,8'h02,8'h00,8'hFF,8'hFF,8'h01,8'h00,8'h02,8'h00,8'h03}, 3, 1, 0, 2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0002);

        // reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst.rx_ready", bus.rx_ready, 1);
        chk("rst.mem_w_en", bus.mem_w_en, 0);
        chk("rst.mem_addr", bus.mem_addr, 0);
        chk("rst.mem_d_out", bus.mem_d_out, 0);
        cmp_end("rst", 0, 0);

        // table of whole frames
        for (int v = 0; v < 6; v++) begin
            do_reset(1'b0, 8'h00);
            q.delete();
            for (int k = 0; k < tbl[v].n; k++) q.push_back(tbl[v].b[k]);
            send_all(q, tbl[v].gap);
            exp_a.delete();
            exp_d.delete();
            for (int k = 0; k < tbl[v].nw; k++) begin
                exp_a.push_back(tbl[v].a[k]);
                exp_d.push_back(tbl[v].d[k]);
            end
            cmp_writes(tbl[v].name);
            foreach (cap_r[k]) chk($sformatf("%s.rx_ready_in_write%0d", tbl[v].name, k), cap_r[k], 0);
            cmp_end(tbl[v].name, tbl[v].done, tbl[v].err);
            if (tbl[v].nw > 0) begin
                chk({tbl[v].name, ".addr_hold"}, bus.mem_addr, tbl[v].a[tbl[v].nw-1]);
                chk({tbl[v].name, ".data_hold"}, bus.mem_d_out, tbl[v].d[tbl[v].nw-1]);
            end
            chk({tbl[v].name, ".rx_ready_end"}, bus.rx_ready, 0);
        end

        // reset one cycle after the first data byte, with a sync byte offered
        do_reset(1'b0, 8'h00);
        q = '{8'hA5,8'h02,8'h00,8'h10,8'h00,8'h34};
        foreach (q[k]) send(q[k], 0);
        do_reset(1'b1, SYNC);
        chk("midrst.rx_ready", bus.rx_ready, 1);
        cmp_end("midrst", 0, 0);
        send_all('{8'hA5,8'h02,8'h00,8'h10,8'h00,8'h34,8'h12,8'h78,8'h56,8'h26}, 0);
        exp_a = '{16'h0010, 16'h0011};
        exp_d = '{16'h1234, 16'h5678};
        cmp_writes("midrst_reload");
        cmp_end("midrst_reload", 1, 0);

        // reset landing exactly on the WRITE cycle
        do_reset(1'b0, 8'h00);
        q = '{8'hA5,8'h01,8'h00,8'h20,8'h00,8'h11,8'h22};
        foreach (q[k]) send(q[k], 0);
        @(negedge clk);
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("wrrst.nwrites", cap_a.size(), 0);
        chk("wrrst.mem_addr", bus.mem_addr, 0);
        cmp_end("wrrst", 0, 0);

        // length exactly at the limit is accepted
        do_reset(1'b0, 8'h00);
        q = '{8'hA5,8'h00,8'h04};
        foreach (q[k]) send(q[k], 0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        chk("maxlen.err", bus.err, 0);
        chk("maxlen.rx_ready", bus.rx_ready, 1);

        // random frames against the reference parser
        for (int f = 0; f < 30; f++) begin
            int          len, gap;
            logic [15:0] base;
            logic [7:0]  s, x;
            do_reset(1'b0, 8'h00);
            q.delete();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                x = 8'($urandom);
                if (x == SYNC) x = 8'h00;
                q.push_back(x);
            end
            q.push_back(SYNC);
            gap = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) begin
                len = MAXW + 1 + $urandom_range(0, 300);
                q.push_back(8'(len));
                q.push_back(8'(len >> 8));
            end else begin
                len  = $urandom_range(0, 4);
                base = ($urandom_range(0, 1) == 1) ? 16'(16'hFFFE + $urandom_range(0, 1)) : 16'($urandom);
                q.push_back(8'(len)); q.push_back(8'h00);
                q.push_back(base[7:0]); q.push_back(base[15:8]);
                for (int k = 0; k < 2 * len; k++) q.push_back(8'($urandom));
                s = 8'h00;
                for (int k = q.size() - 4 - 2 * len; k < q.size(); k++) s = s + q[k];
                if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
                q.push_back(s);
            end
            model(q, m_done, m_err);
            send_all(q, gap);
            cmp_writes($sformatf("rand%0d", f));
            cmp_end($sformatf("rand%0d", f), m_done, m_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
